nibble_serial_adder: RTL

Multi-cycle N-bit adder that sequences wide operands through the existing `four_bit_adder` one nibble per clock, least-significant nibble first. It registers the inter-nibble carry between cycles and assembles the full-width sum. It sits directly upstream of, and wraps, the `four_bit_adder` datapath. Valid/ready handshakes on both sides let it drop into the arithmetic pipeline where a full-width combinational adder is too slow or too large.

---
 rtl/adder_pkg.sv | 19 +
 rtl/four_bit_adder.sv | 28 ++
 rtl/full_adder.sv | 15 +
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the serial nibble adder: FSM states, nibble width and
// the helper that sizes the nibble index counter.
// Ports: none (package).
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // A single-nibble adder still needs a 1-bit index so the counter has a legal width.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Four-bit ripple-carry adder built from full_adder cells.
// Latency: combinational. Backpressure: none.
// Ports: a[3:0], b[3:0], cin in; sum[3:0], cout out.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[4];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: combinational. Backpressure: none.
// Ports: a, b, cin in; sum, cout out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one nibble per clock through four_bit_adder, LSB nibble first.
// Latency: NIBBLES cycles from accept edge to out_valid; one op per NIBBLES+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, stalls upstream otherwise.
// Ports: clk, rst_n; in_valid/in_ready with a, b, cin; out_valid/out_ready with sum, cout; busy.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int IDX_W = idx_width(NIBBLES);

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [WIDTH-1:0]      a_reg;
  logic [WIDTH-1:0]      b_reg;
  logic                  carry_reg;
  logic [WIDTH-1:0]      sum_reg;
  logic                  cout_reg;
  logic                  out_valid_reg;
  logic                  last_nib;
  logic [NIBBLE_W-1:0]   a_nib;
  logic [NIBBLE_W-1:0]   b_nib;
  logic [NIBBLE_W-1:0]   nib_sum;
  logic                  nib_cout;

  assign last_nib = (idx == IDX_W'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ADD;
      ADD:     if (last_nib)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // Nibble select: a compare-and-mux per nibble keeps the index arithmetic
  // out of the part-select and stays legal for any NIBBLES.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  four_bit_adder u_nib_add (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_reg),
    .sum (nib_sum),
    .cout(nib_cout)
  );

  // Operand capture, carry chaining across cycles and sum assembly.
  // Operands are captured only on an IDLE accept, so in_valid while busy is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
          end
        end
        ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
              sum_reg[i*NIBBLE_W +: NIBBLE_W] <= nib_sum;
            end
          end
          carry_reg <= nib_cout;
          // idx parks on the last nibble instead of wrapping; the next accept reloads it.
          if (last_nib) begin
            cout_reg <= nib_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // out_valid is a flop that tracks entry to / exit from DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= (state_nxt == DONE);
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule
